// File: rtl/bp_stall_counter_sampler_if.sv
// bp_stall_counter_sampler_if: valid/ready word stream from the stall-counter sampler toward the host FIFO
interface bp_stall_counter_sampler_if #(parameter int width_p = 32);
   logic [width_p-1:0] data;
   logic v;
   logic ready;
   modport master(output data, v, input ready);
   modport slave(input data, v, output ready);
endinterface

// File: rtl/bp_stall_counter_sampler.sv
// bp_stall_counter_sampler: periodic coherent snapshot of the stall counter bank, streamed as seq header + counters
// Define BP_STALL_SAMPLER_CLEAR_EN to pulse clear_o on each capture (per-interval deltas instead of cumulative counts).
module bp_stall_counter_sampler #(
   parameter int width_p = 32,
   parameter int num_counters_p = 32,
   parameter int interval_width_p = 32
) (
   input  logic clk_i,
   input  logic reset_i,
   input  logic enable_i,
   input  logic [interval_width_p-1:0] interval_i,
   input  logic [num_counters_p*width_p-1:0] counters_i,
   output logic clear_o,
   output logic busy_o,
   output logic [width_p-1:0] overrun_o,
   bp_stall_counter_sampler_if.master stream
);
   localparam int idx_w = $clog2(num_counters_p + 1);
   typedef enum logic [1:0] {IDLE, COUNT, DRAIN} state_e;
   state_e state;
   logic [interval_width_p-1:0] timer;
   logic [interval_width_p-1:0] reload;
   logic [width_p-1:0] seq;
   logic [idx_w-1:0] idx;
   logic last;
   // words[0] is the header, frozen at capture so overruns during drain cannot disturb it
   logic [width_p-1:0] words [num_counters_p+1];
   assign reload = interval_i - interval_width_p'(1);
   assign last = idx == idx_w'(num_counters_p);
   assign stream.v = state == DRAIN;
   assign stream.data = state == DRAIN ? words[idx] : '0;
   assign busy_o = state == DRAIN;
`ifdef BP_STALL_SAMPLER_CLEAR_EN
   assign clear_o = state == COUNT && timer == '0;
`else
   assign clear_o = 1'b0;
`endif
   always_ff @(posedge clk_i or posedge reset_i)
      if (reset_i) begin
         state <= IDLE;
         timer <= '0;
         seq <= '0;
         idx <= '0;
         overrun_o <= '0;
         for (int k = 0; k <= num_counters_p; k++) words[k] <= '0;
      end else
         case (state)
            IDLE:
               if (enable_i && interval_i != '0) begin
                  state <= COUNT;
                  timer <= reload;
               end
            COUNT:
               if (timer == '0) begin
                  words[0] <= seq + width_p'(1);
                  for (int k = 0; k < num_counters_p; k++) words[k+1] <= counters_i[k*width_p +: width_p];
                  seq <= seq + width_p'(1);
                  timer <= reload;
                  idx <= '0;
                  state <= DRAIN;
               end else if (!enable_i || interval_i == '0)
                  state <= IDLE;
               else
                  timer <= timer - interval_width_p'(1);
            DRAIN: begin
               // timer only runs while enabled; an expiry here is a dropped sample
               if (enable_i && timer == '0) begin
                  timer <= reload;
                  seq <= seq + width_p'(1);
                  overrun_o <= overrun_o + width_p'(~&overrun_o);
               end else if (enable_i)
                  timer <= timer - interval_width_p'(1);
               if (stream.ready) begin
                  idx <= idx + idx_w'(1);
                  if (last) state <= enable_i && interval_i != '0 ? COUNT : IDLE;
               end
            end
            default: state <= IDLE;
         endcase
endmodule

// File: tb/tb_bp_stall_counter_sampler.sv
// tb_bp_stall_counter_sampler: scoreboard bench for the stall counter sampler
module tb_bp_stall_counter_sampler;
   localparam int w = 32;
   localparam int n = 4;
`ifdef BP_STALL_SAMPLER_CLEAR_EN
   localparam bit clear_en = 1'b1;
`else
   localparam bit clear_en = 1'b0;
`endif
   logic clk = 0, rst = 1, enable = 0, clear, busy;
   logic [31:0] interval = 0;
   logic [n*w-1:0] counters = {32'd4, 32'd3, 32'd2, 32'd1};
   logic [w-1:0] overrun;
   int passed = 0, total = 0;
   logic [w-1:0] exp_q [$];
   logic [w-1:0] exp_w, held;
   logic stalled = 0;
   bp_stall_counter_sampler_if #(.width_p(w)) stream ();
   bp_stall_counter_sampler #(.width_p(w), .num_counters_p(n), .interval_width_p(32)) dut (
      .clk_i(clk), .reset_i(rst), .enable_i(enable), .interval_i(interval), .counters_i(counters),
      .clear_o(clear), .busy_o(busy), .overrun_o(overrun), .stream(stream.master));
   always #5 clk = ~clk;
   // one cycle: scoreboard the word about to be accepted at the coming edge, then step past that edge
   task automatic step();
      @(negedge clk);
      if (rst) stalled = 0;
      else begin
         if (stalled) begin
            total++;
            if (stream.v !== 1'b1 || stream.data !== held)
               $display("FAIL hold: v=%b data=%0d, required v=1 data=%0d", stream.v, stream.data, held);
            else passed++;
         end
         if (stream.v === 1'b1 && stream.ready === 1'b1) begin
            total++;
            if (exp_q.size() == 0) $display("FAIL word: got %0d, required no word", stream.data);
            else begin
               exp_w = exp_q.pop_front();
               if (stream.data !== exp_w) $display("FAIL word: got %0d, required %0d", stream.data, exp_w);
               else passed++;
            end
         end
         stalled = stream.v === 1'b1 && stream.ready === 1'b0;
         held = stream.data;
      end
      @(posedge clk);
      #1;
   endtask
   task automatic push_sample(input logic [w-1:0] hdr);
      exp_q.push_back(hdr);
      for (int k = 1; k <= n; k++) exp_q.push_back(w'(k));
   endtask
   task automatic wait_v(input int budget);
      for (int i = 0; i < budget && stream.v !== 1'b1; i++) step();
   endtask
   task automatic wait_empty(input int budget);
      for (int i = 0; i < budget && (exp_q.size() != 0 || busy !== 1'b0); i++) step();
   endtask
   task automatic test_reset();
      stream.ready = 1;
      step();
      step();
      total++;
      if (stream.v !== 0 || stream.data !== 0) $display("FAIL reset_stream: v=%b data=%0d, required 0 0", stream.v, stream.data);
      else passed++;
      total++;
      if (clear !== 0 || busy !== 0 || overrun !== 0)
         $display("FAIL reset_ctrl: clear=%b busy=%b overrun=%0d, required 0 0 0", clear, busy, overrun);
      else passed++;
      rst = 0;
      step();
   endtask
   task automatic test_basic();
      int early = 0, late = 0;
      push_sample(1);
      interval = 20;
      enable = 1;
      for (int c = 1; c <= 19; c++) begin
         step();
         if (clear !== 0 || stream.v !== 0 || busy !== 0) early++;
      end
      total++;
      if (early !== 0) $display("FAIL basic_early: %0d active cycles, required 0", early);
      else passed++;
      step();
      total++;
      if (clear !== clear_en || stream.v !== 0) $display("FAIL basic_expiry: clear=%b v=%b, required %b 0", clear, stream.v, clear_en);
      else passed++;
      step();
      total++;
      if (stream.v !== 1 || busy !== 1 || stream.data !== 1) $display("FAIL basic_first: v=%b busy=%b data=%0d, required 1 1 1", stream.v, busy, stream.data);
      else passed++;
      for (int c = 0; c < 5; c++) begin
         if (clear !== 0) late++;
         step();
      end
      total++;
      if (busy !== 0 || stream.v !== 0 || exp_q.size() != 0 || late !== 0)
         $display("FAIL basic_done: busy=%b v=%b left=%0d clears=%0d, required 0 0 0 0", busy, stream.v, exp_q.size(), late);
      else passed++;
      enable = 0;
      step();
      step();
   endtask
   task automatic test_backpressure();
      bit seen = 0, done = 0;
      push_sample(2);
      enable = 1;
      for (int i = 0; i < 200 && !done; i++) begin
         stream.ready = ~stream.ready;
         step();
         if (busy) seen = 1;
         else if (seen) done = 1;
      end
      enable = 0;
      stream.ready = 1;
      total++;
      if (!done || exp_q.size() != 0 || overrun !== 0)
         $display("FAIL backpressure: done=%b left=%0d overrun=%0d, required 1 0 0", done, exp_q.size(), overrun);
      else passed++;
      step();
      step();
   endtask
   task automatic test_overrun();
      rst = 1;
      step();
      rst = 0;
      step();
      push_sample(1);
      push_sample(5);
      interval = 3;
      stream.ready = 0;
      enable = 1;
      wait_v(50);
      total++;
      if (stream.v !== 1) $display("FAIL overrun_start: v=%b, required 1", stream.v);
      else passed++;
      repeat (6) step();
      interval = 40;
      repeat (2) step();
      total++;
      if (overrun !== 2) $display("FAIL overrun_9: overrun=%0d, required 2", overrun);
      else passed++;
      step();
      total++;
      if (overrun !== 3) $display("FAIL overrun_10: overrun=%0d, required 3", overrun);
      else passed++;
      stream.ready = 1;
      for (int i = 0; i < 200 && exp_q.size() != 0; i++) step();
      total++;
      if (exp_q.size() != 0) $display("FAIL overrun_drain: %0d words left, required 0", exp_q.size());
      else passed++;
   endtask
   task automatic test_reset_drain();
      stream.ready = 0;
      wait_v(100);
      total++;
      if (stream.v !== 1 || stream.data !== 6) $display("FAIL rdrain_hdr: v=%b data=%0d, required 1 6", stream.v, stream.data);
      else passed++;
      exp_q.push_back(6);
      exp_q.push_back(1);
      stream.ready = 1;
      step();
      step();
      stream.ready = 0;
      #2 rst = 1;
      #1;
      total++;
      if (stream.v !== 0 || busy !== 0 || overrun !== 0 || stream.data !== 0 || exp_q.size() != 0)
         $display("FAIL rdrain_async: v=%b busy=%b overrun=%0d data=%0d left=%0d, required 0 0 0 0 0", stream.v, busy, overrun, stream.data, exp_q.size());
      else passed++;
      step();
      rst = 0;
      interval = 20;
      stream.ready = 1;
      push_sample(1);
      wait_empty(100);
      total++;
      if (exp_q.size() != 0 || busy !== 0) $display("FAIL rdrain_after: left=%0d busy=%b, required 0 0", exp_q.size(), busy);
      else passed++;
      enable = 0;
      step();
   endtask
   task automatic test_disable_drain();
      int act = 0;
      push_sample(2);
      interval = 20;
      enable = 1;
      wait_v(50);
      repeat (3) step();
      enable = 0;
      total++;
      if (busy !== 1 || exp_q.size() != 2) $display("FAIL disable_mid: busy=%b left=%0d, required 1 2", busy, exp_q.size());
      else passed++;
      repeat (2) step();
      total++;
      if (busy !== 0 || exp_q.size() != 0) $display("FAIL disable_end: busy=%b left=%0d, required 0 0", busy, exp_q.size());
      else passed++;
      for (int i = 0; i < 40; i++) begin
         step();
         if (stream.v !== 0 || clear !== 0 || busy !== 0) act++;
      end
      total++;
      if (act !== 0) $display("FAIL disable_idle: %0d active cycles, required 0", act);
      else passed++;
   endtask
   task automatic test_interval0();
      int act = 0;
      interval = 0;
      enable = 1;
      for (int i = 0; i < 50; i++) begin
         step();
         if (stream.v !== 0 || clear !== 0 || busy !== 0) act++;
      end
      total++;
      if (act !== 0) $display("FAIL interval0: %0d active cycles, required 0", act);
      else passed++;
      enable = 0;
   endtask
   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_overrun();
      test_reset_drain();
      test_disable_drain();
      test_interval0();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
